if_id_stage: RTL and testbench
==============================

// Module: if_id_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register for the 5-stage MIPS core. Owns the PC, drives the
//  instruction-memory address, and captures fetched words into IF/ID. Consumes the hazard unit's
//  stallpc/stall/flush and the branch/jump redirect. Its id_instruction/id_rs/id_rt outputs feed
//  the hazard unit and the decode stage.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR 32'h0000_0000  word inserted into IF/ID on flush (all-zero = sll $0,$0,0)
// PORTS
//  clk              in   1   single clock, all state on rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  imem_addr        out  32  = pc; instruction memory reads combinationally (same cycle)
//  imem_rdata       in   32  instruction word at imem_addr
//  stallpc          in   1   hold PC this cycle
//  stall            in   1   hold IF/ID contents this cycle
//  flush            in   1   replace IF/ID contents with NOP_INSTR this cycle
//  redirect_valid   in   1   branch/jump taken, one-cycle pulse
//  redirect_target  in   32  redirect destination PC
//  id_instruction   out  32  IF/ID instruction register
//  id_pc_plus4      out  32  IF/ID pc+4 of that instruction
//  id_rs            out  5   id_instruction[25:21]
//  id_rt            out  5   id_instruction[20:16]
//  id_valid         out  1   IF/ID holds a real fetched instruction
//  redirect_pending out  1   1 while a redirect is parked waiting for stallpc to drop
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, id_instruction=NOP_INSTR, id_pc_plus4=0, id_valid=0,
//   redirect_pending=0, saved_target=0, state=BOOT. All outputs registered except imem_addr/id_rs/id_rt.
//  FSM states: BOOT, RUN, HOLD.
//   BOOT: one cycle after rst_n rises; no PC update, IF/ID unchanged; -> RUN unconditionally.
//   RUN:  redirect_valid & stallpc  -> saved_target<=redirect_target, -> HOLD.
//         redirect_valid & !stallpc -> pc<=redirect_target, stay RUN.
//         !redirect_valid & !stallpc -> pc<=pc+4 (mod 2^32: 32'hFFFF_FFFC wraps to 0).
//         stallpc & !redirect_valid -> pc holds.
//   HOLD: stallpc=1 -> pc holds; a new redirect_valid overwrites saved_target (latest wins).
//         stallpc=0 -> pc<=redirect_valid ? redirect_target : saved_target, -> RUN.
//  redirect_pending = (state==HOLD).
//  Target alignment: redirect_target[1:0] ignored; PC loaded with {target[31:2],2'b00}.
//  IF/ID update, priority flush > stall > load (evaluated every cycle except BOOT):
//   flush: id_instruction<=NOP_INSTR, id_pc_plus4<=0, id_valid<=0.
//   stall: all IF/ID registers hold.
//   load:  in RUN: id_instruction<=imem_rdata, id_pc_plus4<=pc+4, id_valid<=1.
//          in HOLD: load NOP_INSTR, id_valid<=0 (wrong-path word never enters decode).
//  Latency: word at pc appears on id_instruction the cycle after its fetch (1 cycle).
//  Simultaneous flush+stall: flush wins. Simultaneous flush+redirect: both act (PC redirects,
//   IF/ID gets NOP). stall without stallpc: PC advances, IF/ID holds (hazard unit's job to avoid).
//  Reset mid-operation: immediate return to reset values; parked redirect discarded.
// STRUCTURE
//  Shared package mips_pipe_pkg: NOP_INSTR, RS_MSB/LSB and RT_MSB/LSB field constants,
//   fetch_state_t enum {BOOT,RUN,HOLD}.
//  One sub-module: ifid_reg (IF/ID register with flush/stall priority, async active-low reset);
//   PC register, next-PC mux and FSM stay in if_id_stage.
// TESTING
//  1 Reset release, no hazards, imem returns addr-derived words -> BOOT 1 cycle, then imem_addr
//    0,4,8,...; id_instruction lags one cycle, id_valid=1 from first load.
//  2 stall=1,stallpc=1 for 3 cycles at pc=0x10 -> imem_addr stays 0x10, IF/ID frozen, resumes 0x14.
//  3 redirect_valid=1 target=0x103 with stallpc=0, flush=1 -> next pc=0x100, id_instruction=0,
//    id_valid=0; following cycle fetches 0x100.
//  4 redirect target=0x200 while stallpc=1, then target=0x300 in HOLD, stallpc drops 2 cycles later
//    -> redirect_pending=1 throughout, IF/ID loads NOPs, pc jumps to 0x300, pending clears.
//  5 flush=1 and stall=1 together -> IF/ID = NOP, id_valid=0 (flush wins).
//  6 pc=0xFFFF_FFFC, no hazards -> next pc=0x0; assert rst_n=0 mid-HOLD -> pc=RESET_PC,
//    redirect_pending=0 immediately, parked target not applied.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core: instruction field
// positions, the NOP encoding and the fetch FSM state type.
package mips_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Word-align a branch/jump target; the low two bits carry no meaning.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority flush > stall > load; the load either
// captures the fetched word or, when fetch is parked on a redirect, a NOP.
module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        update,
  input  logic        flush,
  input  logic        stall,
  input  logic        load_real,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc_plus4,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (update) begin
      if (flush) begin
        instr_d    = NOP_INSTR;
        pc_plus4_d = 32'h0;
        valid_d    = 1'b0;
      end else if (!stall) begin
        if (load_real) begin
          instr_d    = fetch_instr;
          pc_plus4_d = fetch_pc_plus4;
          valid_d    = 1'b1;
        end else begin
          // Wrong-path word fetched while a redirect is parked: drop it.
          instr_d    = NOP_INSTR;
          pc_plus4_d = 32'h0;
          valid_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign pc_plus4    = pc_plus4_q;
  assign valid       = valid_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC register, next-PC selection with parked-redirect FSM, and
// the IF/ID register feeding decode and the hazard unit.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stallpc,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc_plus4,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic        id_valid,
  output logic        redirect_pending
);

  import mips_pipe_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  saved_target_q, saved_target_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target_aligned;

  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = align_pc(redirect_target);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    saved_target_d = saved_target_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          if (stallpc) begin
            saved_target_d = target_aligned;
            state_d        = HOLD;
          end else begin
            pc_d = target_aligned;
          end
        end else if (!stallpc) begin
          pc_d = pc_plus4;
        end
      end
      HOLD: begin
        if (stallpc) begin
          // Latest redirect wins while parked.
          if (redirect_valid) saved_target_d = target_aligned;
        end else begin
          pc_d    = redirect_valid ? target_aligned : saved_target_q;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      saved_target_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      saved_target_q <= saved_target_d;
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .update        (state_q != BOOT),
    .flush         (flush),
    .stall         (stall),
    .load_real     (state_q == RUN),
    .fetch_instr   (imem_rdata),
    .fetch_pc_plus4(pc_plus4),
    .instruction   (id_instruction),
    .pc_plus4      (id_pc_plus4),
    .valid         (id_valid)
  );

  assign imem_addr        = pc_q;
  assign id_rs            = id_instruction[RS_MSB:RS_LSB];
  assign id_rt            = id_instruction[RT_MSB:RT_LSB];
  assign redirect_pending = (state_q == HOLD);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage; instruction memory returns ~address so
// every fetched word is predictable from its PC.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_rdata;
  logic        stallpc, stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] id_instruction, id_pc_plus4;
  logic [4:0]  id_rs, id_rt;
  logic        id_valid, redirect_pending;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  if_id_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stallpc         (stallpc),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_instruction  (id_instruction),
    .id_pc_plus4     (id_pc_plus4),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_valid        (id_valid),
    .redirect_pending(redirect_pending)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic spc, input logic stl, input logic fl, input logic rv,
                       input logic [31:0] tgt);
    stallpc         = spc;
    stall           = stl;
    flush           = fl;
    redirect_valid  = rv;
    redirect_target = tgt;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic vld);
    check_eq({tag, ".instr"}, id_instruction, instr);
    check_eq({tag, ".pc4"}, id_pc_plus4, pc4);
    check_eq({tag, ".valid"}, {31'h0, id_valid}, {31'h0, vld});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    check_eq("rst.pc", imem_addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check_eq("rst.pending", {31'h0, redirect_pending}, 32'h0);

    // 1: boot cycle, then sequential fetch with one-cycle IF/ID lag
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("boot.pc", imem_addr, 32'h0);
    check_eq("boot.valid", {31'h0, id_valid}, 32'h0);
    tick();
    check_eq("seq1.pc", imem_addr, 32'h4);
    check_ifid("seq1", 32'hFFFF_FFFF, 32'h4, 1'b1);
    tick();
    check_eq("seq2.pc", imem_addr, 32'h8);
    check_ifid("seq2", ~32'h4, 32'h8, 1'b1);
    tick();
    tick();
    check_eq("seq4.pc", imem_addr, 32'h10);
    check_ifid("seq4", ~32'hC, 32'h10, 1'b1);
    check_eq("seq4.rs", {27'h0, id_rs}, {27'h0, 5'h1F});
    check_eq("seq4.rt", {27'h0, id_rt}, {27'h0, 5'h1F});

    // 2: three-cycle stall at pc=0x10
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall.pc", imem_addr, 32'h10);
      check_eq("stall.instr", id_instruction, ~32'hC);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("resume.pc", imem_addr, 32'h14);
    check_ifid("resume", ~32'h10, 32'h14, 1'b1);

    // 3: redirect with misaligned target plus flush
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h103);
    tick();
    check_eq("redir.pc", imem_addr, 32'h100);
    check_ifid("redir", 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("redir2.pc", imem_addr, 32'h104);
    check_ifid("redir2", ~32'h100, 32'h104, 1'b1);

    // 4: redirect parked under stallpc, overwritten in HOLD
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
    tick();
    check_eq("park.pending", {31'h0, redirect_pending}, 32'h1);
    check_eq("park.pc", imem_addr, 32'h104);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
    tick();
    check_eq("hold1.pending", {31'h0, redirect_pending}, 32'h1);
    check_ifid("hold1", 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("hold2.pending", {31'h0, redirect_pending}, 32'h1);
    check_eq("hold2.pc", imem_addr, 32'h104);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("unpark.pc", imem_addr, 32'h300);
    check_eq("unpark.pending", {31'h0, redirect_pending}, 32'h0);
    check_ifid("unpark", 32'h0, 32'h0, 1'b0);
    tick();
    check_eq("after.pc", imem_addr, 32'h304);
    check_ifid("after", ~32'h300, 32'h304, 1'b1);

    // 5: flush and stall together
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check_ifid("flst", 32'h0, 32'h0, 1'b0);
    check_eq("flst.pc", imem_addr, 32'h308);

    // 6: PC wrap, then reset while parked
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap0.pc", imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("wrap.pc", imem_addr, 32'h0);
    check_ifid("wrap", 32'h3, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h500);
    tick();
    check_eq("park2.pending", {31'h0, redirect_pending}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst.pc", imem_addr, 32'h0);
    check_eq("mrst.pending", {31'h0, redirect_pending}, 32'h0);
    check_eq("mrst.valid", {31'h0, id_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("mrst2.pc", imem_addr, 32'h4);
    check_eq("mrst2.pending", {31'h0, redirect_pending}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
